// File: rtl/zilla_hazard_unit.sv
// Pipeline hazard unit: load-use interlock, MDU multicycle stall with watchdog, branch-flush bubble.
// Latency: all control outputs combinational from current inputs and registered EX shadows/FSM state.
// Backpressure: stall_pipeline freezes PC, IF/ID and ID/EX; a flush or a load-use hazard turns ID/EX into a bubble.
//
// Ports:
//   hzd_clk, hzd_rst              clock, asynchronous active-high reset
//   id_rs1/id_rs2, *_used         source registers of the ID instruction and whether they are read
//   id_rd, id_mem_rd_en           destination and load flag of the ID instruction
//   id_mdu_op, mdu_done_i         multicycle div/rem issue and its completion pulse
//   flush_i                       taken branch/jump resolved in EX
//   stall_pipeline, pc_wr_en_o,
//   if_id_wr_en_o, id_ex_bubble_o pipeline control
//   mdu_timeout_o                 one-cycle watchdog abort pulse
//   stall_cnt_o                   saturating stall-cycle counter
module zilla_hazard_unit #(
   parameter int GPR_ADDR_WIDTH = 5,
   parameter int MDU_TIMEOUT    = 64
) (
   input  logic                      hzd_clk,
   input  logic                      hzd_rst,
   input  logic [GPR_ADDR_WIDTH-1:0] id_rs1,
   input  logic [GPR_ADDR_WIDTH-1:0] id_rs2,
   input  logic                      id_rs1_used,
   input  logic                      id_rs2_used,
   input  logic [GPR_ADDR_WIDTH-1:0] id_rd,
   input  logic                      id_mem_rd_en,
   input  logic                      id_mdu_op,
   input  logic                      mdu_done_i,
   input  logic                      flush_i,
   output logic                      stall_pipeline,
   output logic                      pc_wr_en_o,
   output logic                      if_id_wr_en_o,
   output logic                      id_ex_bubble_o,
   output logic                      mdu_timeout_o,
   output logic [15:0]               stall_cnt_o
);

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MDU_WAIT = 1'b1
   } state_t;

   localparam logic [6:0] WCNT_LAST = 7'(MDU_TIMEOUT - 1);

   state_t                    state_q, state_d;
   logic [6:0]                wcnt_q, wcnt_d;
   logic [GPR_ADDR_WIDTH-1:0] ex_rd_q, ex_rd_d;
   logic                      ex_load_q, ex_load_d;
   logic [15:0]               stall_cnt_q, stall_cnt_d;

   logic load_use;
   logic stall_s;
   logic bubble_s;
   logic timeout_s;

   // x0 is hardwired zero, so a load targeting it never creates a hazard.
   assign load_use = ex_load_q && (ex_rd_q != '0) &&
                     ((id_rs1_used && (id_rs1 == ex_rd_q)) ||
                      (id_rs2_used && (id_rs2 == ex_rd_q)));

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      ex_rd_d   = ex_rd_q;
      ex_load_d = ex_load_q;
      stall_s   = 1'b0;
      bubble_s  = 1'b0;
      timeout_s = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A flush kills the dependent instruction anyway, so it overrides the interlock.
            stall_s  = load_use && !flush_i;
            bubble_s = load_use || flush_i;
            // The bubble clears ex_load, which guarantees the load-use stall lasts one cycle.
            if (bubble_s) begin
               ex_rd_d   = '0;
               ex_load_d = 1'b0;
            end else begin
               ex_rd_d   = id_rd;
               ex_load_d = id_mem_rd_en;
            end
            if (id_mdu_op && !stall_s && !flush_i) begin
               state_d = ST_MDU_WAIT;
               wcnt_d  = '0;
            end
         end
         ST_MDU_WAIT: begin
            // Flush and load-use are not evaluated here: the instruction in EX predates any branch.
            // A completing MDU on the last allowed cycle is treated as done, not aborted.
            timeout_s = !mdu_done_i && (wcnt_q == WCNT_LAST);
            stall_s   = !mdu_done_i && !timeout_s;
            if (mdu_done_i || timeout_s) begin
               state_d = ST_IDLE;
            end else begin
               wcnt_d = wcnt_q + 7'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      stall_cnt_d = stall_cnt_q;
      if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge hzd_clk or posedge hzd_rst) begin
      if (hzd_rst) begin
         state_q     <= ST_IDLE;
         wcnt_q      <= '0;
         ex_rd_q     <= '0;
         ex_load_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         ex_rd_q     <= ex_rd_d;
         ex_load_q   <= ex_load_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_pipeline = stall_s;
   assign pc_wr_en_o     = !stall_s;
   assign if_id_wr_en_o  = !stall_s;
   assign id_ex_bubble_o = bubble_s;
   assign mdu_timeout_o  = timeout_s;
   assign stall_cnt_o    = stall_cnt_q;

endmodule
